aes_inv_cipher_iter: RTL and testbench

Iterative AES-128 decryption core (FIPS-197 inverse cipher). It is the stand-alone decrypt-direction counterpart to the team's AES encryption datapath and consumes that block's ciphertext. Takes a 128-bit ciphertext and the cipher key through a valid/ready handshake. Expands the key forward to round key 10, then runs the 10 inverse rounds one per clock while regenerating round keys backwards. Returns plaintext through a valid/ready handshake.

---
 rtl/aes_inv_cipher_iter.sv | 198 +++++++++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: forward key expansion to rk10, then one inverse round per clock
// with the round keys regenerated backwards from rk10.
module aes_inv_cipher_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] datain,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dec_text,
  output logic         busy
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d};

  typedef enum logic [2:0] {IDLE, KEYEXP, ROUND, LAST, DONE} state_t;

  state_t       state, state_next;
  logic [3:0]   cnt, cnt_next;
  logic [127:0] rk, rk_next, st, st_next, dec_next;
  logic         out_valid_next;
  logic [31:0]  sw_in, sw_out;
  logic [31:0]  w0f, w1f, w2f, w3f, w0i, w1i, w2i, w3i;
  logic [127:0] rk_fwd, rk_inv, isb, ark, st_round;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) multiply by a 4-bit constant (bits select b, 2b, 4b, 8b)
  function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return (m[0] ? b : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gm(a0,4'he) ^ gm(a1,4'hb) ^ gm(a2,4'hd) ^ gm(a3,4'h9),
            gm(a0,4'h9) ^ gm(a1,4'he) ^ gm(a2,4'hb) ^ gm(a3,4'hd),
            gm(a0,4'hd) ^ gm(a1,4'h9) ^ gm(a2,4'he) ^ gm(a3,4'hb),
            gm(a0,4'hb) ^ gm(a1,4'hd) ^ gm(a2,4'h9) ^ gm(a3,4'he)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Shared SubWord(RotWord()) ^ Rcon: forward step uses w3, inverse step uses the recovered w3'
  assign sw_in  = (state == KEYEXP) ? rk[31:0] : w3i;
  assign sw_out = {SBOX[sw_in[23:16]], SBOX[sw_in[15:8]], SBOX[sw_in[7:0]], SBOX[sw_in[31:24]]}
                  ^ {rcon(cnt), 24'h0};

  // Forward and inverse key steps
  assign w0f    = rk[127:96] ^ sw_out;
  assign w1f    = rk[95:64] ^ w0f;
  assign w2f    = rk[63:32] ^ w1f;
  assign w3f    = rk[31:0] ^ w2f;
  assign rk_fwd = {w0f, w1f, w2f, w3f};
  assign w3i    = rk[31:0] ^ rk[63:32];
  assign w2i    = rk[63:32] ^ rk[95:64];
  assign w1i    = rk[95:64] ^ rk[127:96];
  assign w0i    = rk[127:96] ^ sw_out;
  assign rk_inv = {w0i, w1i, w2i, w3i};

  // InvShiftRows + InvSubBytes (byte r of column c comes from column c-r), then AddRoundKey and InvMixColumns
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign isb[127-8*(4*c+r) -: 8] = INV_SBOX[st[127-8*(4*((c+4-r)%4)+r) -: 8]];
    end
    assign st_round[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
  end
  assign ark = isb ^ rk_inv;

  // Next-state and datapath next values
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    rk_next        = rk;
    st_next        = st;
    dec_next       = dec_text;
    out_valid_next = out_valid;
    case (state)
      IDLE: begin
        if (in_valid) begin
          rk_next    = key;
          st_next    = datain;
          cnt_next   = 4'd1;
          state_next = KEYEXP;
        end
      end
      KEYEXP: begin
        rk_next  = rk_fwd;
        cnt_next = cnt + 4'd1;
        if (cnt == 4'd10) begin
          st_next    = st ^ rk_fwd;
          cnt_next   = 4'd10;
          state_next = ROUND;
        end
      end
      ROUND: begin
        rk_next  = rk_inv;
        st_next  = st_round;
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd2) state_next = LAST;
      end
      LAST: begin
        rk_next        = rk_inv;
        dec_next       = ark;
        out_valid_next = 1'b1;
        cnt_next       = cnt - 4'd1;
        state_next     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rk        <= '0;
      st        <= '0;
      dec_text  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      rk        <= rk_next;
      st        <= st_next;
      dec_text  <= dec_next;
      out_valid <= out_valid_next;
      in_ready  <= (state_next == IDLE);
      busy      <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Scoreboard bench for aes_inv_cipher_iter: random plaintexts are encrypted by a forward AES model,
// the ciphertext is decrypted by the DUT and compared against the original plaintext.
module tb_aes_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] datain = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] dec_text;

  int n_cmp = 0;
  int n_err = 0;
  logic [127:0] exp_q [$];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic [7:0] sbox [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

  aes_inv_cipher_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .key(key), .datain(datain),
    .out_valid(out_valid), .out_ready(out_ready), .dec_text(dec_text), .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Textbook AES-128 encryption with a fully expanded 44-word schedule
  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] x;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    x = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      for (int b = 0; b < 16; b++) s[b] = sbox[x[127-8*b -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[4*c+rr] = s[4*((c+rr)%4)+rr];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int b = 0; b < 16; b++) x[127-8*b -: 8] = t[b];
      x = x ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return x;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one block once the core is idle; returns just after the accept edge
  task automatic send(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    check("in_ready_before_send", 128'(in_ready), 128'(1'b1));
    in_valid = 1'b1;
    key      = k;
    datain   = c;
    tick();
    in_valid = 1'b0;
    exp_q.push_back(p);
    check("busy_after_accept", 128'(busy), 128'(1'b1));
  endtask

  // Wait (bounded) for out_valid; n is the number of edges waited
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 60) begin tick(); n++; end
    check("out_valid_timeout", 128'(out_valid), 128'(1'b1));
  endtask

  // Monitor: compare each delivered plaintext against the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got %h expected no output", dec_text);
      end else begin
        check("dec_text", dec_text, exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [127:0] p, k, c;

    // Reset state
    tick(); tick();
    check("reset_flags", 128'({in_ready, out_valid, busy}), 128'(3'b100));
    check("reset_dec_text", dec_text, 128'h0);
    rst = 1'b0;
    tick();

    // C.1 with latency measurement
    out_ready = 1'b1;
    send(C1_KEY, C1_CT, C1_PT);
    wait_out(n);
    check("c1_latency", 128'(n), 128'(20));
    tick();
    check("c1_idle_after", 128'({in_ready, out_valid, busy}), 128'(3'b100));

    // Appendix B with key-expansion probe
    send(B_KEY, B_CT, B_PT);
    repeat (10) tick();
    check("b_rk10", dut.rk, B_RK10);
    wait_out(n);
    tick();

    // Backpressure: hold 7 cycles with out_ready low
    out_ready = 1'b0;
    p = rand128(); k = rand128(); c = aes_enc(p, k);
    send(k, c, p);
    wait_out(n);
    for (int i = 0; i < 7; i++) begin
      check("bp_flags", 128'({out_valid, in_ready, busy}), 128'(3'b101));
      check("bp_data", dec_text, p);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_after_handshake", 128'({out_valid, in_ready, busy}), 128'(3'b010));
    check("bp_dec_held", dec_text, p);

    // Input stability: disturb inputs while busy
    p = rand128(); k = rand128(); c = aes_enc(p, k);
    send(k, c, p);
    for (int i = 0; i < 15; i++) begin
      key      = rand128();
      datain   = rand128();
      in_valid = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    wait_out(n);
    tick();
    tick();
    check("no_second_accept", 128'(busy), 128'(1'b0));

    // Reset mid-round, then C.1 again
    send(C1_KEY, C1_CT, C1_PT);
    repeat (12) tick();
    rst = 1'b1;
    #1;
    check("midreset_flags", 128'({out_valid, in_ready, busy}), 128'(3'b010));
    check("midreset_dec_text", dec_text, 128'h0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    send(C1_KEY, C1_CT, C1_PT);
    wait_out(n);
    tick();

    // Back-to-back with in_valid held high
    in_valid = 1'b1;
    key      = C1_KEY;
    datain   = C1_CT;
    tick();
    exp_q.push_back(C1_PT);
    key    = B_KEY;
    datain = B_CT;
    wait_out(n);
    tick();
    check("b2b_idle_after_handshake", 128'({in_ready, busy}), 128'(2'b10));
    tick();
    check("b2b_second_accept", 128'(busy), 128'(1'b1));
    exp_q.push_back(B_PT);
    in_valid = 1'b0;
    wait_out(n);
    tick();

    // Random blocks with random output stalls
    for (int t = 0; t < 8; t++) begin
      out_ready = 1'b0;
      p = rand128(); k = rand128(); c = aes_enc(p, k);
      send(k, c, p);
      wait_out(n);
      repeat ($urandom_range(0, 3)) tick();
      out_ready = 1'b1;
      tick();
    end

    tick();
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
